// File: rtl/scroll_datapath.sv
// Scrolling seven-segment message datapath: prescaled step tick, circular
// message buffer with a moving display window, and a rotating LED register.
module scroll_datapath #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 16,
  parameter int SEG_W      = 7,
  parameter int LED_W      = 10,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
  input  logic [SEG_W-1:0]            wr_data,
  input  logic [1:0]                  mode,
  input  logic                        ledr_en,
  input  logic [LED_W-1:0]            ledr_in,
  output logic [NUM_DIGITS*SEG_W-1:0] hex_out,
  output logic [LED_W-1:0]            ledr_out,
  output logic [$clog2(MSG_LEN)-1:0]  offset,
  output logic                        tick
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [AW-1:0] OFF_LAST  = AW'(MSG_LEN - 1);
  localparam logic [AW:0]   MSG_LEN_W = (AW+1)'(MSG_LEN);

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_LEFT     = 2'b01,
    MODE_RIGHT    = 2'b10,
    MODE_HOLD_ALT = 2'b11
  } mode_e;

  mode_e                       mode_s;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [AW-1:0]               off_q, off_d;
  logic [SEG_W-1:0]            msg_q [MSG_LEN];
  logic [SEG_W-1:0]            msg_d [MSG_LEN];
  logic [NUM_DIGITS*SEG_W-1:0] hex_q, hex_d;
  logic [LED_W-1:0]            led_q, led_d;
  logic [LED_W-1:0]            led_rotl, led_rotr;
  logic                        tick_s;
  logic                        addr_ok;
  int unsigned                 idx;

  assign mode_s  = mode_e'(mode);
  assign tick_s  = (cnt_q == CNT_LAST);
  assign addr_ok = ({1'b0, wr_addr} < MSG_LEN_W);

  // Shift-based rotation stays legal for any LED_W, including 1.
  assign led_rotl = (led_q << 1) | (led_q >> (LED_W - 1));
  assign led_rotr = (led_q >> 1) | (led_q << (LED_W - 1));

  always_comb begin
    cnt_d = tick_s ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    off_d = off_q;
    if (tick_s) begin
      case (mode_s)
        MODE_LEFT:  off_d = (off_q == OFF_LAST) ? '0 : off_q + AW'(1);
        MODE_RIGHT: off_d = (off_q == '0) ? OFF_LAST : off_q - AW'(1);
        default:    off_d = off_q;
      endcase
    end
  end

  always_comb begin
    msg_d = msg_q;
    if (wr_en && addr_ok) begin
      msg_d[wr_addr] = wr_data;
    end
  end

  // Window index never exceeds 2*MSG_LEN-2, so one conditional subtract wraps it.
  always_comb begin
    hex_d = '1;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx = 32'(off_q) + 32'(NUM_DIGITS - 1) - k;
      if (idx >= 32'(MSG_LEN)) begin
        idx = idx - 32'(MSG_LEN);
      end
      hex_d[k*SEG_W +: SEG_W] = msg_q[idx[AW-1:0]];
    end
  end

  always_comb begin
    led_d = led_q;
    if (ledr_en) begin
      led_d = ledr_in;
    end else if (tick_s) begin
      case (mode_s)
        MODE_LEFT:  led_d = led_rotl;
        MODE_RIGHT: led_d = led_rotr;
        default:    led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      off_q <= '0;
      hex_q <= '1;
      led_q <= '0;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= '1;
      end
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
      hex_q <= hex_d;
      led_q <= led_d;
      msg_q <= msg_d;
    end
  end

  assign hex_out  = hex_q;
  assign ledr_out = led_q;
  assign offset   = off_q;
  assign tick     = tick_s;

endmodule
